// File: rtl/nbody_pair_sched.sv
`default_nettype none
// ============================================================================
// Module      : nbody_pair_sched
// Description : Walks every ordered (i,j) body pair of an N-body force pass.
//               It issues dual-port memory reads, feeds the getAccl pipeline
//               and re-attaches pair indices to the pipeline results through
//               a fixed-latency sideband delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module nbody_pair_sched #(
  parameter int Latency  = 122,
  parameter int AddrBits = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AddrBits:0]   num_bodies,
  output logic                busy,
  output logic                done,
  output logic                mem_rd_en,
  output logic [AddrBits-1:0] mem_addr_i,
  output logic [AddrBits-1:0] mem_addr_j,
  input  logic [63:0]         mem_xi,
  input  logic [63:0]         mem_yi,
  input  logic [63:0]         mem_xj,
  input  logic [63:0]         mem_yj,
  input  logic [63:0]         mem_mj,
  output logic [63:0]         pipe_x1,
  output logic [63:0]         pipe_y1,
  output logic [63:0]         pipe_x2,
  output logic [63:0]         pipe_y2,
  output logic [63:0]         pipe_m2,
  input  logic [63:0]         pipe_ax,
  input  logic [63:0]         pipe_ay,
  output logic                res_valid,
  output logic [AddrBits-1:0] res_i,
  output logic [AddrBits-1:0] res_j,
  output logic                res_last,
  output logic [63:0]         res_ax,
  output logic [63:0]         res_ay
);

  // Drain counter must hold the value Latency.
  localparam int                CntW       = $clog2(Latency + 1) + 1;
  localparam logic [CntW-1:0]   DRAIN_LAST = CntW'(Latency);
  localparam logic [AddrBits:0] ONE        = (AddrBits + 1)'(1);
  localparam logic [AddrBits:0] TWO        = (AddrBits + 1)'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AddrBits:0]   n_q, n_d;
  logic [AddrBits:0]   i_q, i_d;
  logic [AddrBits:0]   j_q, j_d;
  logic [CntW-1:0]     drain_q, drain_d;

  // Sideband delay line: stage k holds the slot issued k+1 cycles ago.
  logic [Latency:0]    sb_valid_q;
  logic [Latency:0]    sb_last_q;
  logic [AddrBits-1:0] sb_i_q [Latency+1];
  logic [AddrBits-1:0] sb_j_q [Latency+1];

  logic                w_issue;
  logic                w_slot_valid;
  logic                w_slot_last;
  logic [AddrBits:0]   w_n_m1;
  logic [AddrBits:0]   w_n_m2;

  assign w_issue      = (state_q == ISSUE);
  assign w_n_m1       = n_q - ONE;
  assign w_n_m2       = n_q - TWO;
  assign w_slot_valid = w_issue && (i_q != j_q);
  // Last real pair of a row: the final column, except on the last row where
  // the final column is the self-pair bubble.
  assign w_slot_last  = w_slot_valid &&
                        ((i_q == w_n_m1) ? (j_q == w_n_m2) : (j_q == w_n_m1));

  // State, pass size, pair counters and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: pair walk with j inner, then fixed-length drain.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_bodies;
          i_d     = '0;
          j_d     = '0;
          drain_d = '0;
          state_d = (num_bodies < TWO) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (j_q == w_n_m1) begin
          j_d = '0;
          if (i_q == w_n_m1) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift each issued slot down the sideband line; reset drops in-flight slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_q <= '0;
      sb_last_q  <= '0;
      for (int k = 0; k <= Latency; k++) begin
        sb_i_q[k] <= '0;
        sb_j_q[k] <= '0;
      end
    end else begin
      sb_valid_q <= {sb_valid_q[Latency-1:0], w_slot_valid};
      sb_last_q  <= {sb_last_q[Latency-1:0], w_slot_last};
      sb_i_q[0]  <= i_q[AddrBits-1:0];
      sb_j_q[0]  <= j_q[AddrBits-1:0];
      for (int k = 1; k <= Latency; k++) begin
        sb_i_q[k] <= sb_i_q[k-1];
        sb_j_q[k] <= sb_j_q[k-1];
      end
    end
  end

  assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign mem_rd_en  = w_issue;
  assign mem_addr_i = i_q[AddrBits-1:0];
  assign mem_addr_j = j_q[AddrBits-1:0];

  // Memory data belongs to the slot in stage 0; a zero mass makes bubbles and
  // idle cycles contribute no acceleration.
  assign pipe_x1 = mem_xi;
  assign pipe_y1 = mem_yi;
  assign pipe_x2 = mem_xj;
  assign pipe_y2 = mem_yj;
  assign pipe_m2 = sb_valid_q[0] ? mem_mj : 64'h0;

  assign res_valid = sb_valid_q[Latency];
  assign res_last  = sb_last_q[Latency];
  assign res_i     = sb_i_q[Latency];
  assign res_j     = sb_j_q[Latency];
  assign res_ax    = pipe_ax;
  assign res_ay    = pipe_ay;

endmodule
`default_nettype wire
